note_sequencer: RTL and testbench

- Plays a song from an external note-event ROM and drives one wave voice, `div` plus `enable`.
- Each ROM entry gives a divisor and a duration counted in tempo ticks. An entry can instead mark end-of-song.
- Sits between the song ROM and a wave instance. Clocked at 2.08 MHz; tempo is the 32 Hz square input.
- Two instances, sharing start/stop, give a two-voice song.

---
 rtl/note_sequencer_if.sv | 24 ++
 rtl/note_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_note_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// ----------------------------------------------------------------------------
// note_sequencer_if
//   Song-ROM bus between a note_sequencer and its note-event ROM.
//
//   rom_addr : entry address driven by the sequencer (registered there)
//   rom_data : entry contents, valid one clk after rom_addr changes
//              [MSB]                    end-of-song flag
//              [DIV_W+DUR_W-1:DIV_W]    duration in tempo ticks
//              [DIV_W-1:0]              divisor (0 = rest)
//
//   master : sequencer side (drives the address)
//   slave  : ROM side (returns the entry)
// ----------------------------------------------------------------------------
interface note_sequencer_if #(
  parameter int ADDR_W = 7,
  parameter int DIV_W  = 17,
  parameter int DUR_W  = 6
);
  logic [ADDR_W-1:0]      rom_addr;
  logic [DUR_W+DIV_W:0]   rom_data;

  modport master (output rom_addr, input  rom_data);
  modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/note_sequencer.sv
// ----------------------------------------------------------------------------
// note_sequencer
//   Walks a note-event ROM and drives one wave voice (div + enable). Each
//   entry holds a divisor and a duration in tempo ticks, or marks the end of
//   the song. Two instances sharing start/stop give a two-voice song.
//
// Ports
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   tempo   : tempo square wave, asynchronous to clk; each rising edge = tick
//   start   : level, sampled in IDLE; plays from address 0
//   stop    : level, aborts playback from any state (highest priority)
//   loop    : on end-of-song restart at address 0 instead of finishing
//   rom     : song-ROM bus (note_sequencer_if.master)
//   div     : divisor for the wave module, held across note changes
//   enable  : wave enable, high while a non-rest note sounds
//   busy    : high in every state except IDLE
//   done    : one-clk pulse on normal song completion
// ----------------------------------------------------------------------------
module note_sequencer #(
  parameter int ADDR_W = 7,
  parameter int DIV_W  = 17,
  parameter int DUR_W  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tempo,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  note_sequencer_if.master   rom,
  output logic [DIV_W-1:0]   div,
  output logic               enable,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_FINISH
  } state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic [DIV_W-1:0]    r_div;
  logic                r_enable;
  logic                r_busy;
  logic                r_done;
  logic [DUR_W-1:0]    r_remain;
  logic                r_pending;

  logic                r_tempo_s1;
  logic                r_tempo_s2;
  logic                r_tempo_d;

  logic                w_tick;
  logic                w_play_tick;
  logic                w_end;
  logic [DUR_W-1:0]    w_dur;
  logic [DIV_W-1:0]    w_divisor;
  logic                w_addr_last;

  // ROM entry fields
  assign w_end     = rom.rom_data[DUR_W+DIV_W];
  assign w_dur     = rom.rom_data[DIV_W+DUR_W-1:DIV_W];
  assign w_divisor = rom.rom_data[DIV_W-1:0];

  assign w_tick      = r_tempo_s2 & ~r_tempo_d;
  // A tick that landed while fetching counts in the first PLAY cycle.
  assign w_play_tick = w_tick | r_pending;
  assign w_addr_last = &r_rom_addr;

  // Two-flop synchronizer plus edge-detect history on tempo.
  // NOTE: every flop here is reset asynchronously; this block holds no
  // memory arrays, so nothing is left without a reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tempo_s1 <= 1'b0;
      r_tempo_s2 <= 1'b0;
      r_tempo_d  <= 1'b0;
    end else begin
      r_tempo_s1 <= tempo;
      r_tempo_s2 <= r_tempo_s1;
      r_tempo_d  <= r_tempo_s2;
    end
  end

  // Sequencer FSM; all outputs are registered alongside the state.
  // NOTE: state and outputs use non-blocking assignments so every flop sees
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rom_addr <= '0;
      r_div      <= '0;
      r_enable   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_remain   <= '0;
      r_pending  <= 1'b0;
    end else begin
      // NOTE: done defaults low each cycle so it is a self-clearing pulse;
      // only the transitions into FINISH raise it.
      r_done <= 1'b0;

      if (stop && (r_state != S_IDLE)) begin
        r_state   <= S_IDLE;
        r_div     <= '0;
        r_enable  <= 1'b0;
        r_busy    <= 1'b0;
        r_pending <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_div     <= '0;
            r_enable  <= 1'b0;
            r_pending <= 1'b0;
            if (start && !stop) begin
              r_rom_addr <= '0;
              r_busy     <= 1'b1;
              r_state    <= S_FETCH;
            end
          end

          S_FETCH: begin
            if (w_tick) r_pending <= 1'b1;
            r_state <= S_LOAD;
          end

          S_LOAD: begin
            if (w_tick) r_pending <= 1'b1;
            if (w_end) begin
              // Looping from address 0 would replay an empty song forever.
              if (loop && (r_rom_addr != '0)) begin
                r_rom_addr <= '0;
                r_state    <= S_FETCH;
              end else begin
                r_done   <= 1'b1;
                r_div    <= '0;
                r_enable <= 1'b0;
                r_state  <= S_FINISH;
              end
            end else begin
              r_div    <= w_divisor;
              r_enable <= |w_divisor;
              r_remain <= (w_dur == '0) ? DUR_W'(1) : w_dur;
              r_state  <= S_PLAY;
            end
          end

          S_PLAY: begin
            if (w_play_tick) begin
              // If the pending flag and a fresh tick coincide, keep one.
              r_pending <= r_pending & w_tick;
              if (r_remain < DUR_W'(2)) begin
                if (w_addr_last) begin
                  r_done   <= 1'b1;
                  r_div    <= '0;
                  r_enable <= 1'b0;
                  r_state  <= S_FINISH;
                end else begin
                  // div/enable stay as-is until the next entry loads.
                  r_rom_addr <= r_rom_addr + ADDR_W'(1);
                  r_state    <= S_FETCH;
                end
              end else begin
                r_remain <= r_remain - DUR_W'(1);
              end
            end
          end

          S_FINISH: begin
            r_div     <= '0;
            r_enable  <= 1'b0;
            r_busy    <= 1'b0;
            r_pending <= 1'b0;
            r_state   <= S_IDLE;
          end

          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign rom.rom_addr = r_rom_addr;
  assign div          = r_div;
  assign enable       = r_enable;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// ----------------------------------------------------------------------------
// tb_note_sequencer
//   Self-checking bench for note_sequencer. A registered ROM model feeds the
//   DUT; tempo edges are spaced widely so the expected note after k ticks
//   follows from the song's cumulative durations alone.
// ----------------------------------------------------------------------------
module tb_note_sequencer;

  localparam int ADDR_W = 7;
  localparam int DIV_W  = 17;
  localparam int DUR_W  = 6;
  localparam int RW     = 1 + DUR_W + DIV_W;
  localparam int DEPTH  = 128;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             tempo = 1'b0;
  logic             start = 1'b0;
  logic             stop  = 1'b0;
  logic             loop  = 1'b0;
  logic [DIV_W-1:0] div;
  logic             enable;
  logic             busy;
  logic             done;

  note_sequencer_if #(.ADDR_W(ADDR_W), .DIV_W(DIV_W), .DUR_W(DUR_W)) rom_bus ();

  note_sequencer #(.ADDR_W(ADDR_W), .DIV_W(DIV_W), .DUR_W(DUR_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tempo  (tempo),
    .start  (start),
    .stop   (stop),
    .loop   (loop),
    .rom    (rom_bus.master),
    .div    (div),
    .enable (enable),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Song ROM with one clk of read latency.
  logic [RW-1:0] rom [DEPTH];
  always @(posedge clk) rom_bus.rom_data <= rom[rom_bus.rom_addr];

  int n_cmp  = 0;
  int n_fail = 0;

  // done pulse monitor
  int   done_cnt  = 0;
  int   done_wide = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (done_prev) done_wide++;
    end
    done_prev = (done === 1'b1);
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One tempo period; outputs have long settled when it returns.
  task automatic pulse_tick();
    tempo = 1'b1;
    step(12);
    tempo = 1'b0;
    step(12);
  endtask

  function automatic logic [RW-1:0] mk(input bit e, input int dur, input int dv);
    return {e, DUR_W'(dur), DIV_W'(dv)};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = mk(1'b1, 0, 0);
  endtask

  task automatic load_song(input int id);
    clear_rom();
    case (id)
      0: begin rom[0] = mk(0, 2, 1000); rom[1] = mk(0, 1, 2000); end
      1: begin rom[0] = mk(0, 1, 300); rom[1] = mk(0, 0, 0); rom[2] = mk(0, 1, 700); end
      2: begin rom[0] = mk(0, 1, 500); end
      3: begin rom[0] = mk(0, 1, 100); rom[1] = mk(0, 1, 200); rom[2] = mk(0, 2, 300); end
      default: ;
    endcase
  endtask

  // ------------------------------------------------------------ song model
  function automatic int song_len();
    int n;
    n = 0;
    while (n < DEPTH && rom[n][RW-1] == 1'b0) n++;
    return n;
  endfunction

  function automatic int eff_dur(input int i);
    int d;
    d = int'(rom[i][DIV_W+DUR_W-1:DIV_W]);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int song_ticks(input int n);
    int t;
    t = 0;
    for (int i = 0; i < n; i++) t += eff_dur(i);
    return t;
  endfunction

  // Looping needs an explicit END past address 0; running off the top ends.
  function automatic bit is_looping(input bit lp, input int n);
    return lp && (n > 0) && (n < DEPTH);
  endfunction

  // Expected outputs k ticks after the song started.
  task automatic check_k(input string tag, input int k, input bit lp);
    int          n, t, kk, acc, idx;
    logic [31:0] e_div;
    logic        e_en, e_busy;
    n = song_len();
    t = song_ticks(n);
    idx = -1;
    if (n == 0 || (!is_looping(lp, n) && k >= t)) begin
      e_div = 0; e_en = 1'b0; e_busy = 1'b0;
    end else begin
      kk  = is_looping(lp, n) ? (k % t) : k;
      acc = 0;
      for (int i = 0; i < n; i++) begin
        acc += eff_dur(i);
        if (kk < acc) begin idx = i; break; end
      end
      e_div  = 32'(rom[idx][DIV_W-1:0]);
      e_en   = (e_div != 0);
      e_busy = 1'b1;
    end
    check($sformatf("%s k%0d div", tag, k), 32'(div), e_div);
    check($sformatf("%s k%0d enable", tag, k), 32'(enable), 32'(e_en));
    check($sformatf("%s k%0d busy", tag, k), 32'(busy), 32'(e_busy));
    if (idx >= 0) check($sformatf("%s k%0d addr", tag, k), 32'(rom_bus.rom_addr), 32'(idx));
  endtask

  task automatic run_song(input string tag, input bit lp, input int k_max);
    int n, t, base;
    bit loops;
    n     = song_len();
    t     = song_ticks(n);
    loops = is_looping(lp, n);
    loop  = lp;
    base  = done_cnt;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(8);
    check_k(tag, 0, lp);
    for (int k = 1; k <= k_max; k++) begin
      pulse_tick();
      check_k(tag, k, lp);
    end
    check($sformatf("%s done count", tag), 32'(done_cnt - base),
          32'((!loops && k_max >= t) ? 1 : 0));
    if (loops) begin
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      check($sformatf("%s stop busy", tag), 32'(busy), 32'd0);
      check($sformatf("%s stop enable", tag), 32'(enable), 32'd0);
      step(4);
      check($sformatf("%s stop no done", tag), 32'(done_cnt - base), 32'd0);
    end
    loop = 1'b0;
  endtask

  // ------------------------------------------------------- directed table
  typedef enum int {A_START, A_TICK, A_STOP} act_e;
  typedef struct {
    int   song;
    bit   lp;
    act_e act;
    int   e_div;
    bit   e_en;
    bit   e_busy;
  } vec_t;

  localparam int NVEC = 14;

  // ------------------------------------------------------------- stimulus
  initial begin
    vec_t vecs [NVEC];
    int   base, cnt, n, t, dv, d;
    bit   found, lp;

    vecs[0]  = '{0, 1'b0, A_START, 1000, 1'b1, 1'b1};
    vecs[1]  = '{0, 1'b0, A_TICK,  1000, 1'b1, 1'b1};
    vecs[2]  = '{0, 1'b0, A_TICK,  2000, 1'b1, 1'b1};
    vecs[3]  = '{0, 1'b0, A_TICK,     0, 1'b0, 1'b0};
    vecs[4]  = '{1, 1'b0, A_START,  300, 1'b1, 1'b1};
    vecs[5]  = '{1, 1'b0, A_TICK,     0, 1'b0, 1'b1};
    vecs[6]  = '{1, 1'b0, A_TICK,   700, 1'b1, 1'b1};
    vecs[7]  = '{1, 1'b0, A_TICK,     0, 1'b0, 1'b0};
    vecs[8]  = '{2, 1'b1, A_START,  500, 1'b1, 1'b1};
    vecs[9]  = '{2, 1'b1, A_TICK,   500, 1'b1, 1'b1};
    vecs[10] = '{2, 1'b1, A_TICK,   500, 1'b1, 1'b1};
    vecs[11] = '{2, 1'b1, A_STOP,     0, 1'b0, 1'b0};
    vecs[12] = '{0, 1'b0, A_START, 1000, 1'b1, 1'b1};
    vecs[13] = '{0, 1'b0, A_STOP,     0, 1'b0, 1'b0};

    clear_rom();

    // Reset state
    step(3);
    check("reset div", 32'(div), 32'd0);
    check("reset enable", 32'(enable), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset rom_addr", 32'(rom_bus.rom_addr), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Table-driven sequences
    for (int i = 0; i < NVEC; i++) begin
      case (vecs[i].act)
        A_START: begin
          load_song(vecs[i].song);
          loop  = vecs[i].lp;
          start = 1'b1;
          step(1);
          start = 1'b0;
          step(8);
        end
        A_TICK: pulse_tick();
        A_STOP: begin
          stop = 1'b1;
          step(1);
          stop = 1'b0;
        end
        default: ;
      endcase
      check($sformatf("vec%0d div", i), 32'(div), 32'(vecs[i].e_div));
      check($sformatf("vec%0d enable", i), 32'(enable), 32'(vecs[i].e_en));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d done", i), 32'(done), 32'd0);
    end
    loop = 1'b0;
    step(4);

    // Basic song, cycle-exact: note out 3 clk after start, 1-clk done
    load_song(0);
    base  = done_cnt;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    check("basic 3clk div", 32'(div), 32'd1000);
    check("basic 3clk enable", 32'(enable), 32'd1);
    pulse_tick();
    check("basic tick1 div", 32'(div), 32'd1000);
    pulse_tick();
    check("basic tick2 div", 32'(div), 32'd2000);
    tempo = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step(1);
      if (done === 1'b1) found = 1'b1;
    end
    check("basic done seen", 32'(found), 32'd1);
    if (found) begin
      check("basic div at done", 32'(div), 32'd0);
      step(1);
      check("basic done width", 32'(done), 32'd0);
      check("basic busy after", 32'(busy), 32'd0);
    end
    tempo = 1'b0;
    step(12);
    check("basic done count", 32'(done_cnt - base), 32'd1);

    // Start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    step(5);
    check("start+stop idle busy", 32'(busy), 32'd0);
    start = 1'b0;
    stop  = 1'b0;
    step(2);

    // Empty song with loop: must finish, not spin
    clear_rom();
    loop  = 1'b1;
    base  = done_cnt;
    start = 1'b1;
    cnt   = 0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step(1);
      start = 1'b0;
      cnt++;
      if (done === 1'b1) found = 1'b1;
    end
    check("empty loop done seen", 32'(found), 32'd1);
    check("empty loop within 4clk", 32'(cnt <= 4), 32'd1);
    step(6);
    check("empty loop idle", 32'(busy), 32'd0);
    loop = 1'b0;

    // Tempo edge during FETCH becomes a pending tick
    load_song(3);
    base  = done_cnt;
    tempo = 1'b1;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    check("gap first note", 32'(div), 32'd100);
    step(3);
    check("gap pending tick ends note", 32'(div), 32'd200);
    tempo = 1'b0;
    step(12);
    pulse_tick();
    check("gap note3 div", 32'(div), 32'd300);
    pulse_tick();
    check("gap note3 held", 32'(div), 32'd300);
    pulse_tick();
    check("gap song over", 32'(busy), 32'd0);
    check("gap done count", 32'(done_cnt - base), 32'd1);

    // Async reset mid-note
    load_song(0);
    base  = done_cnt;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(8);
    check("areset pre div", 32'(div), 32'd1000);
    #2 rst_n = 1'b0;
    #1;
    check("areset div", 32'(div), 32'd0);
    check("areset enable", 32'(enable), 32'd0);
    check("areset busy", 32'(busy), 32'd0);
    check("areset rom_addr", 32'(rom_bus.rom_addr), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(2);
    check("areset no done", 32'(done_cnt - base), 32'd0);

    // Address wrap: 128 notes, no END, loop set -> finishes after 127
    for (int i = 0; i < DEPTH; i++) rom[i] = mk(1'b0, 1, i + 1);
    run_song("wrap", 1'b1, DEPTH + 2);
    check("wrap addr held", 32'(rom_bus.rom_addr), 32'd127);

    // Random songs against the tick-timeline model
    for (int s = 0; s < 16; s++) begin
      clear_rom();
      n = int'($urandom_range(0, 8));
      for (int i = 0; i < n; i++) begin
        dv = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, (1 << DIV_W) - 1));
        d  = int'($urandom_range(0, 3));
        rom[i] = mk(1'b0, d, dv);
      end
      lp = 1'($urandom_range(0, 1));
      t  = song_ticks(n);
      run_song($sformatf("rnd%0d", s), lp, is_looping(lp, n) ? 2 * t + 1 : t + 1);
    end

    check("done pulse width", 32'(done_wide), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
